// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Writes a stream of 32-bit instruction words into the CPU instruction memory,
// starting at byte address 0. A zero word terminates the program and is itself
// written. The CPU is held in reset until the image is complete.
//
// Handshake: a word transfers on a rising edge where in_valid_i and in_ready_o
// are both high. The sender holds in_data_i stable until that edge and may
// drop in_valid_i without a transfer. in_ready_o is registered and is high
// only while loading, so a transfer can never occur outside LOAD.
//
// state_o exposes the FSM state (IDLE=0, LOAD=1, DONE=2) for debug.

module instr_mem_loader #(
    parameter int MEM_DEPTH = 32,
    parameter int CNT_W     = 6
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             in_valid_i,
    input  logic [31:0]      in_data_i,
    output logic             in_ready_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_o,
    output logic             cpu_rst_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] word_count_o,
    output logic [1:0]       state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             xfer;
    logic             load_start;
    logic             is_term;
    logic             fills_mem;
    logic [CNT_W-1:0] count_inc;

    assign state_o = state;

    // Decode the transfer, the start of a new load and the end-of-image cases
    always_comb begin
        xfer       = 1'b0;
        load_start = 1'b0;
        is_term    = 1'b0;
        fills_mem  = 1'b0;
        count_inc  = word_count_o + ONE_C;

        // in_ready_o is only ever high in LOAD, but gate on state as well so
        // a stray ready can never produce a write elsewhere.
        if (state == S_LOAD) begin
            xfer = in_valid_i & in_ready_o;
        end

        if ((state == S_IDLE) || (state == S_DONE)) begin
            load_start = start_i;
        end

        if (xfer) begin
            is_term   = (in_data_i == 32'd0);
            fills_mem = (count_inc == DEPTH_C);
        end
    end

    // Next-state selection: a terminator or the last free slot ends the load
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (is_term || fills_mem) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (load_start) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and the status outputs decoded from the next state
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            cpu_rst_n_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_o  <= (state_nxt == S_LOAD);
            busy_o      <= (state_nxt == S_LOAD);
            done_o      <= (state_nxt == S_DONE);
            cpu_rst_n_o <= (state_nxt == S_DONE);
        end
    end

    // Memory write port: one write pulse in the cycle after each transfer
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= 32'd0;
            mem_data_o <= 32'd0;
        end else begin
            mem_we_o <= xfer;
            if (xfer) begin
                mem_addr_o <= {{(30-CNT_W){1'b0}}, word_count_o, 2'b00};
                mem_data_o <= in_data_i;
            end
        end
    end

    // Word counter and overflow flag: cleared on start, held in DONE
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            word_count_o <= '0;
            overflow_o   <= 1'b0;
        end else if (load_start) begin
            word_count_o <= '0;
            overflow_o   <= 1'b0;
        end else if (xfer) begin
            // The FSM leaves LOAD once MEM_DEPTH words are written; the
            // saturation guard keeps the count bounded regardless.
            if (word_count_o != DEPTH_C) begin
                word_count_o <= count_inc;
            end
            // A terminator landing in the last slot is a complete image.
            overflow_o <= fills_mem & ~is_term;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: random images with random valid gaps,
// expected memory writes derived from the image contents alone.

module tb_instr_mem_loader;

  localparam int MEM_DEPTH = 32;
  localparam int CNT_W     = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start_i;
  logic             in_valid_i;
  logic [31:0]      in_data_i;
  logic             in_ready_o;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_data_o;
  logic             cpu_rst_n_o;
  logic             busy_o;
  logic             done_o;
  logic             overflow_o;
  logic [CNT_W-1:0] word_count_o;
  logic [1:0]       state_o;

  instr_mem_loader #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .cpu_rst_n_o  (cpu_rst_n_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o),
    .word_count_o (word_count_o),
    .state_o      (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];      // {byte address, data} of each expected write
  logic [31:0] img[$];        // image offered to the loader
  int          exp_cnt;
  logic        exp_ovf;
  logic        mon_en = 1'b0;
  logic        xfer_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Protocol observation: was there a transfer at this edge?
  always @(posedge clk) xfer_prev <= rst_n && in_valid_i && in_ready_o;

  // Monitor: every write pulse must match the head of the expected queue,
  // and a pulse appears exactly in the cycle after a transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_after_xfer", {31'd0, mem_we_o}, {31'd0, xfer_prev});
      if (mem_we_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr_o, mem_data_o);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("write_addr", mem_addr_o, e[63:32]);
          chk("write_data", mem_data_o, e[31:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Words are written in order from address 0 until (and including) the first
  // zero word, or until the memory is full; full without a zero is overflow.
  task automatic model_image();
    exp_cnt = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({32'(i * 4), img[i]});
      exp_cnt++;
      if (img[i] == 32'd0) break;
      if (exp_cnt == MEM_DEPTH) begin
        exp_ovf = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    chk("start_busy", {31'd0, busy_o}, 32'd1);
    chk("start_cpu_rst", {31'd0, cpu_rst_n_o}, 32'd0);
    chk("start_done", {31'd0, done_o}, 32'd0);
    chk("start_count", 32'(word_count_o), 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int budget;
    in_valid_i = 1'b0;
    repeat (gap) cycle();
    in_valid_i = 1'b1;
    in_data_i  = w;
    budget = 50;
    while (in_ready_o !== 1'b1 && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) begin
      chk("send_timeout", 32'd1, 32'd0);
    end else begin
      cycle();
    end
    in_valid_i = 1'b0;
    in_data_i  = $urandom();
  endtask

  // Send the part of img the model says will be accepted, then check status.
  task automatic load_image(input int gapmax);
    model_image();
    do_start();
    for (int i = 0; i < exp_cnt; i++) send_word(img[i], $urandom_range(0, gapmax));
    @(negedge clk);
    #1;
    chk("end_done", {31'd0, done_o}, 32'd1);
    chk("end_cpu_rst", {31'd0, cpu_rst_n_o}, 32'd1);
    chk("end_busy", {31'd0, busy_o}, 32'd0);
    chk("end_ready", {31'd0, in_ready_o}, 32'd0);
    chk("end_overflow", {31'd0, overflow_o}, {31'd0, exp_ovf});
    chk("end_count", 32'(word_count_o), 32'(exp_cnt));
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    cycle();
  endtask

  task automatic rand_image(input int len);
    logic [31:0] w;
    img.delete();
    for (int i = 0; i < len; i++) begin
      w = $urandom();
      if (w == 32'd0) w = 32'd1;
      img.push_back(w);
    end
    img.push_back(32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = 32'd0;

    // 1: reset with random inputs
    repeat (2) begin
      start_i    = 1'($urandom_range(0, 1));
      in_valid_i = 1'($urandom_range(0, 1));
      in_data_i  = $urandom();
      cycle();
    end
    mon_en = 1'b1;
    chk("rst_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_data", mem_data_o, 32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst_n_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_overflow", {31'd0, overflow_o}, 32'd0);
    chk("rst_count", 32'(word_count_o), 32'd0);
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    rst_n      = 1'b1;
    cycle();
    chk("idle_ready", {31'd0, in_ready_o}, 32'd0);

    // 2: fixed image back-to-back
    img = '{32'h20080005, 32'h20090007, 32'h01095020, 32'h0};
    load_image(0);

    // 3: same image with gaps 0-3 (start from DONE)
    load_image(3);

    // random images with random gaps
    for (int t = 0; t < 5; t++) begin
      rand_image($urandom_range(0, 12));
      load_image($urandom_range(0, 2));
    end

    // 6: from DONE, 2-word image
    img = '{32'h00000013, 32'h0};
    load_image(1);

    // terminator in the last slot: not an overflow
    rand_image(MEM_DEPTH - 1);
    load_image(0);

    // 4: 32 nonzero words, then a 33rd must not be accepted
    rand_image(MEM_DEPTH);
    void'(img.pop_back());
    img.push_back(32'hDEADBEEF);
    load_image(1);
    in_valid_i = 1'b1;
    in_data_i  = 32'h12345678;
    repeat (4) begin
      cycle();
      chk("extra_ready", {31'd0, in_ready_o}, 32'd0);
    end
    in_valid_i = 1'b0;
    chk("extra_count", 32'(word_count_o), 32'(MEM_DEPTH));
    chk("extra_overflow", {31'd0, overflow_o}, 32'd1);

    // 5: reset after 2 transfers in LOAD
    img = '{32'h11111111, 32'h22222222};
    exp_q.push_back({32'd0, img[0]});
    exp_q.push_back({32'd4, img[1]});
    do_start();
    send_word(img[0], 0);
    send_word(img[1], 1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("midrst_count", 32'(word_count_o), 32'd0);
    chk("midrst_cpu_rst", {31'd0, cpu_rst_n_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready_o}, 32'd0);
    in_valid_i = 1'b1;
    in_data_i  = 32'h33333333;
    repeat (4) cycle();
    in_valid_i = 1'b0;
    chk("midrst_state", 32'(state_o), 32'd0);
    repeat (2) cycle();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
